// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: reset defaults, FSM state encoding and
// the NPC alignment predicate.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry data register: captures a word on load, drops it on clear.
module fetch_hold_buf
    import fetch_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// MIPS F stage: PC register, single-outstanding imem request FSM, F/D register.
// Optional NPC alignment check enabled by defining FETCH_ALIGN_CHK_EN.
module f_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NPC,
    input  logic        D_stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic        D_valid,
    output logic        fetch_err
);

    fetch_state_t state_q, state_d;
    logic         advance;
    logic         hold_load;
    logic         hold_clear;
    logic         hold_valid;
    logic [31:0]  hold_data;
    logic [31:0]  adv_word;

    fetch_hold_buf #(.W(32)) u_hold (
        .clk   (clk),
        .rst   (reset),
        .load  (hold_load),
        .clear (hold_clear),
        .din   (imem_rsp_data),
        .dout  (hold_data),
        .valid (hold_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_REQ;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:  if (imem_req_ready) state_d = S_WAIT;
            S_WAIT: if (imem_rsp_valid) state_d = D_stall ? S_HOLD : S_REQ;
            S_HOLD: if (!D_stall) state_d = S_REQ;
            S_ERR:  state_d = S_ERR;
        endcase
`ifdef FETCH_ALIGN_CHK_EN
        if (advance && misaligned(NPC)) state_d = S_ERR;
`endif
    end

    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        hold_load      = (state_q == S_WAIT) && imem_rsp_valid && D_stall;
        hold_clear     = (state_q == S_HOLD) && !D_stall;
        advance        = ((state_q == S_WAIT) && imem_rsp_valid && !D_stall) ||
                         ((state_q == S_HOLD) && hold_valid && !D_stall);
        adv_word       = (state_q == S_HOLD) ? hold_data : imem_rsp_data;
    end

    // Any unstalled cycle without an advance pushes a bubble into D.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_PC    <= RESET_PC;
            D_PC    <= '0;
            D_Instr <= NOP_INSTR;
            D_valid <= 1'b0;
        end else begin
            if (advance) F_PC <= NPC;
            if (!D_stall) begin
                if (advance) begin
                    D_PC    <= F_PC;
                    D_Instr <= adv_word;
                    D_valid <= 1'b1;
                end else begin
                    D_Instr <= NOP_INSTR;
                    D_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    assign imem_addr = F_PC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              fetch_err <= 1'b0;
        else if (advance && misaligned(NPC))    fetch_err <= 1'b1;
    end
`else
    assign imem_addr = {F_PC[31:2], 2'b00};
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_f_fetch_unit;

`ifdef FETCH_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] NPC = '0;
    logic        D_stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] F_PC, D_PC, D_Instr;
    logic        D_valid, fetch_err;

    f_fetch_unit #(.RESET_PC(32'h0000_3000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .NPC(NPC), .D_stall(D_stall),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .F_PC(F_PC), .D_PC(D_PC),
        .D_Instr(D_Instr), .D_valid(D_valid), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int unsigned n_assert = 0;
    int unsigned n_fail = 0;

    // reference model: request pending / awaiting response / word parked
    bit          m_req, m_pend, m_hold, m_dval, m_err;
    logic [31:0] m_hword, m_fpc, m_dpc, m_dins;
    bit          mem_busy;
    int unsigned mem_lat;

    // stimulus knobs
    int unsigned p_ready, p_stall, max_lat, npc_mode, stall_left;
    bit          spur;
    logic [31:0] npc_fix;
    logic [31:0] acc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 1; m_pend = 0; m_hold = 0; m_dval = 0; m_err = 0;
        m_hword = '0; m_fpc = 32'h0000_3000; m_dpc = '0; m_dins = '0;
        mem_busy = 0; mem_lat = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, m_req});
        chk({tag, ".addr"}, imem_addr, ALIGN ? m_fpc : (m_fpc & 32'hFFFF_FFFC));
        chk({tag, ".F_PC"}, F_PC, m_fpc);
        chk({tag, ".D_PC"}, D_PC, m_dpc);
        chk({tag, ".D_Instr"}, D_Instr, m_dins);
        chk({tag, ".D_valid"}, {31'b0, D_valid}, {31'b0, m_dval});
        chk({tag, ".fetch_err"}, {31'b0, fetch_err}, {31'b0, m_err});
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cycle(input string tag);
        bit          rv, rdy, stl, adv, old_req;
        logic [31:0] rd, np, w, r;
        rv = 0; rd = $urandom();
        if (mem_busy) begin
            if (mem_lat <= 1) begin rv = 1; mem_busy = 0; end
            else mem_lat--;
        end else if (spur && $urandom_range(0, 7) == 0) begin
            rv = 1;
        end
        rdy = ($urandom_range(0, 99) < p_ready);
        if (stall_left > 0) begin stl = 1; stall_left--; end
        else stl = ($urandom_range(0, 99) < p_stall);
        r = $urandom();
        case (npc_mode)
            0: np = m_fpc + 32'd4;
            1: np = r & 32'hFFFF_FFFC;
            2: np = r;
            default: np = npc_fix;
        endcase
        imem_rsp_valid = rv; imem_rsp_data = rd; imem_req_ready = rdy;
        D_stall = stl; NPC = np;
        if (m_req && rdy) acc_q.push_back(imem_addr);
        @(posedge clk);
        adv = 0; w = '0; old_req = m_req;
        if (m_pend && rv) begin
            m_pend = 0;
            if (!stl) begin adv = 1; w = rd; end
            else begin m_hold = 1; m_hword = rd; end
        end else if (m_hold && !stl) begin
            adv = 1; w = m_hword; m_hold = 0;
        end
        if (old_req && rdy) begin
            m_req = 0; m_pend = 1; mem_busy = 1;
            mem_lat = $urandom_range(1, max_lat);
        end
        if (!stl) begin
            if (adv) begin m_dpc = m_fpc; m_dins = w; m_dval = 1; end
            else begin m_dins = '0; m_dval = 0; end
        end
        if (adv) begin
            m_fpc = np;
            if (ALIGN && np[1:0] != 2'b00) m_err = 1;
            else m_req = 1;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1;
        imem_rsp_valid = 0; imem_req_ready = 0; D_stall = 0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        chk({tag, ".rel_req"}, {31'b0, imem_req_valid}, 32'd1);
        chk({tag, ".rel_fpc"}, F_PC, 32'h0000_3000);
        chk({tag, ".rel_dval"}, {31'b0, D_valid}, 32'd0);
    endtask

    initial begin
        bit found;
        p_ready = 100; p_stall = 0; max_lat = 1; npc_mode = 0;
        stall_left = 0; spur = 0; npc_fix = '0;
        @(negedge clk);
        do_reset("rst");

        // ready held low: address parked, only bubbles
        p_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle("rdy_low");
            chk("rdy_low.addr", imem_addr, 32'h0000_3000);
            chk("rdy_low.dval", {31'b0, D_valid}, 32'd0);
        end

        // streaming: ready=1, 1-cycle memory, sequential NPC
        p_ready = 100;
        acc_q.delete();
        for (int i = 0; i < 8; i++) cycle("stream");
        found = (acc_q.size() >= 3);
        chk("stream.nreq", {31'b0, found}, 32'd1);
        if (found) begin
            chk("stream.a0", acc_q[0], 32'h0000_3000);
            chk("stream.a1", acc_q[1], 32'h0000_3004);
            chk("stream.a2", acc_q[2], 32'h0000_3008);
        end

        // stall coinciding with a response: word goes through the hold buffer
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_pend) begin stall_left = 3; found = 1; end
            cycle("stall");
        end
        chk("stall.hit", {31'b0, found}, 32'd1);
        for (int i = 0; i < 6; i++) cycle("stall_after");

        // branch: delay slot 0x300C fetched, then redirect to 0x3100
        do_reset("br_rst");
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle("br_pre");
            found = (m_fpc == 32'h0000_300C);
        end
        chk("br.reach", {31'b0, found}, 32'd1);
        npc_mode = 3; npc_fix = 32'h0000_3100;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle("br");
            found = (m_fpc == 32'h0000_3100);
        end
        chk("br.adv", {31'b0, found}, 32'd1);
        chk("br.dpc", D_PC, 32'h0000_300C);
        chk("br.addr", imem_addr, 32'h0000_3100);

        // misaligned NPC
        npc_fix = 32'h0000_3102;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle("mis");
            found = (m_fpc == 32'h0000_3102);
        end
        chk("mis.adv", {31'b0, found}, 32'd1);
        chk("mis.err", {31'b0, fetch_err}, {31'b0, ALIGN});
        chk("mis.addr", imem_addr, ALIGN ? 32'h0000_3102 : 32'h0000_3100);
        for (int i = 0; i < 5; i++) begin
            cycle("mis_after");
            if (ALIGN) chk("mis.noreq", {31'b0, imem_req_valid}, 32'd0);
        end

        // reset while waiting on a slow response
        npc_mode = 0; max_lat = 4;
        do_reset("wait_rst0");
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle("wait_pre");
            found = m_pend;
        end
        chk("wait.reach", {31'b0, found}, 32'd1);
        do_reset("wait_rst");

        // randomized traffic
        for (int b = 0; b < 6; b++) begin
            p_ready = $urandom_range(20, 100);
            p_stall = $urandom_range(0, 60);
            max_lat = $urandom_range(1, 5);
            spur = 1;
            do_reset("rnd_rst");
            for (int i = 0; i < 300; i++) begin
                r_pick: begin
                    int unsigned k;
                    k = $urandom_range(0, 99);
                    npc_mode = (k < 70) ? 0 : (k < 96) ? 1 : 2;
                end
                cycle("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
